// File: rtl/image_tx_pkg.sv
// -----------------------------------------------------------------------------
// image_tx_pkg
// Shared definitions for the image transfer path (UART receiver, BRAM wrapper,
// image_tx_streamer): frame size, BRAM address/pixel widths and the streamer
// state encoding.
// -----------------------------------------------------------------------------
package image_tx_pkg;

  localparam int NUM_PIXELS_DEF = 784;  // 28x28 image, one byte per pixel
  localparam int ADDR_W         = 10;   // BRAM address width
  localparam int PIX_W          = 8;    // BRAM data width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START_BIT,
    ST_DATA_BIT,
    ST_STOP_BIT
  } tx_state_e;

endpackage

// File: rtl/image_tx_streamer_if.sv
// -----------------------------------------------------------------------------
// image_tx_streamer_if
// Signal bundle between image_tx_streamer and its environment.
//   tick     : baud enable at OVERSAMPLE x baud, one clk wide
//   start    : frame request pulse
//   data_ram : BRAM port B read data (one clk after addr_b)
//   addr_b   : BRAM port B read address
//   tx       : UART serial output, idle high
//   busy     : streamer not in IDLE
//   done     : one-clk pulse at the end of the last stop bit of a frame
// Modports: master = streamer side, slave = environment side.
// -----------------------------------------------------------------------------
interface image_tx_streamer_if;
  import image_tx_pkg::*;

  logic              tick;
  logic              start;
  logic [PIX_W-1:0]  data_ram;
  logic [ADDR_W-1:0] addr_b;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    input  tick, start, data_ram,
    output addr_b, tx, busy, done
  );

  modport slave (
    output tick, start, data_ram,
    input  addr_b, tx, busy, done
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Bit-level UART transmitter datapath: shift register, oversample tick counter,
// data bit counter and the registered tx line. Sequencing is owned by the
// streamer FSM; this block follows the state it is given.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture data_byte, start the start bit (tx low)
//   data_byte  : character to send, LSB first
//   tick       : oversample enable, counted only in the bit states
//   state      : current streamer state
//   tx         : serial output
//   bit_done   : current bit period ends this clk
//   last_data  : bit_done on the final data bit
//   char_done  : bit_done on the stop bit
// OVERSAMPLE must not exceed 16 (tick_cnt is 4 bits).
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import image_tx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_byte,
  input  logic                 tick,
  input  tx_state_e            state,
  output logic                 tx,
  output logic                 bit_done,
  output logic                 last_data,
  output logic                 char_done
);

  localparam int              BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_shifted;
  logic [3:0]           tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 counting;

  // Ticks arriving during FETCH/LOAD are deliberately dropped.
  assign counting      = state inside {ST_START_BIT, ST_DATA_BIT, ST_STOP_BIT};
  assign bit_done      = counting && tick && (tick_cnt == TICK_LAST);
  assign last_data     = bit_done && (state == ST_DATA_BIT) && (bit_cnt == BIT_LAST);
  assign char_done     = bit_done && (state == ST_STOP_BIT);
  assign shreg_shifted = shreg >> 1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else if (load) begin
      shreg    <= data_byte;
      tick_cnt <= '0;
      tx       <= 1'b0;
    end else begin
      if (counting && tick)
        tick_cnt <= bit_done ? 4'd0 : tick_cnt + 4'd1;

      if (bit_done) begin
        case (state)
          ST_START_BIT: begin
            tx      <= shreg[0];
            bit_cnt <= '0;
          end
          ST_DATA_BIT: begin
            if (bit_cnt == BIT_LAST) begin
              tx <= 1'b1;                 // stop bit
            end else begin
              shreg   <= shreg_shifted;
              tx      <= shreg_shifted[0];
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          default: ;                      // stop bit keeps tx high
        endcase
      end
    end
  end

endmodule

// File: rtl/image_tx_streamer.sv
// -----------------------------------------------------------------------------
// image_tx_streamer
// Streams a NUM_PIXELS-byte frame from BRAM port B out of a UART, one 8N1
// character per byte, address 0 first.
//   clk  : system clock (shared with BRAM port B)
//   rst  : asynchronous active-high reset, aborts a frame immediately
//   bus  : image_tx_streamer_if.master (tick, start, data_ram in;
//          addr_b, tx, busy, done out)
// Per byte: FETCH (BRAM read latency), LOAD (capture, tx low), then start,
// data and stop bits of OVERSAMPLE ticks each.
// -----------------------------------------------------------------------------
module image_tx_streamer
  import image_tx_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  image_tx_streamer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  tx_state_e         state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              load, done;
  logic              bit_done, last_data, char_done, ser_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    load      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_FETCH;
          addr_nxt  = '0;
        end
      end
      ST_FETCH:     state_nxt = ST_LOAD;
      ST_LOAD: begin
        load      = 1'b1;
        state_nxt = ST_START_BIT;
      end
      ST_START_BIT: if (bit_done)  state_nxt = ST_DATA_BIT;
      ST_DATA_BIT:  if (last_data) state_nxt = ST_STOP_BIT;
      ST_STOP_BIT: begin
        if (char_done) begin
          if (addr == LAST_ADDR) begin
            // done is issued while still in STOP_BIT, so a start arriving
            // with it is not seen by IDLE.
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
            done      = 1'b1;
          end else begin
            state_nxt = ST_FETCH;
            addr_nxt  = addr + ADDR_W'(1);
          end
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  uart_tx_serializer #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_byte (DATA_BITS'(bus.data_ram)),
    .tick      (bus.tick),
    .state     (state),
    .tx        (ser_tx),
    .bit_done  (bit_done),
    .last_data (last_data),
    .char_done (char_done)
  );

  assign bus.addr_b = addr;
  assign bus.tx     = ser_tx;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = done;

endmodule
